// File: rtl/disc_write_memctl_pkg.sv
// Shared definitions for the disc write memory controller: FSM encoding,
// engine opcodes and the default RAM address width.
package disc_write_memctl_pkg;

   localparam int ADDR_W_DEF = 17;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_HRD   = 3'd1,
      ST_PRIME = 3'd2,
      ST_ARM   = 3'd3,
      ST_RUN   = 3'd4,
      ST_DONE  = 3'd5
   } state_e;

   localparam logic [7:0] OP_WRGATE_OFF  = 8'h00;
   localparam logic [7:0] OP_WRGATE_ON   = 8'h01;
   localparam logic [7:0] OP_WRITE_PULSE = 8'h02;
   localparam logic [7:0] OP_WAIT_HSTM   = 8'h03;
   localparam logic [7:0] OP_STOP        = 8'h3F;

   // Run-in-progress states, during which the host is locked out of the RAM.
   function automatic logic is_busy_state(state_e s);
      return (s == ST_PRIME) || (s == ST_ARM) || (s == ST_RUN) || (s == ST_DONE);
   endfunction

endpackage

// File: rtl/disc_write_memctl_prefetch.sv
// Two-byte instruction prefetch: cur holds RAM[eptr], the RAM output holds
// RAM[eptr+1], and the look-ahead address keeps that true across commits.
module disc_write_memctl_prefetch
   import disc_write_memctl_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clock_i,
   input  logic              reset_i,
   input  logic              load_i,
   input  logic [ADDR_W-1:0] base_i,
   input  logic              active_i,
   input  logic              clken_i,
   input  logic              eng_inc_i,
   input  logic [7:0]        mem_rdata_i,
   output logic [7:0]        eng_mdat_o,
   output logic [ADDR_W-1:0] fetch_addr_o,
   output logic              wrap_o
);

   logic [ADDR_W-1:0] eptr_q, eptr_d;
   logic [7:0]        cur_q, cur_d;
   logic              commit;

   assign commit = active_i & clken_i & eng_inc_i;

   always_comb begin
      eptr_d = eptr_q;
      cur_d  = cur_q;
      if (load_i) begin
         eptr_d = base_i - ADDR_W'(1);
      end else if (commit) begin
         eptr_d = eptr_q + ADDR_W'(1);
         cur_d  = mem_rdata_i;
      end
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         eptr_q <= '0;
         cur_q  <= OP_STOP;
      end else begin
         eptr_q <= eptr_d;
         cur_q  <= cur_d;
      end
   end

   // On a commit, fetch one further ahead so the next clock already shows RAM[eptr+2].
   assign fetch_addr_o = eptr_q + ADDR_W'(1) + ADDR_W'(commit);
   assign eng_mdat_o   = eng_inc_i ? mem_rdata_i : cur_q;
   assign wrap_o       = commit & (&eptr_q);

endmodule

// File: rtl/disc_write_memctl.sv
// Waveform RAM arbiter and write-run sequencer: host byte load/readback while
// idle, instruction prefetch for the write engine while a run is in progress.
module disc_write_memctl
   import disc_write_memctl_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clock_i,
   input  logic              reset_i,
   input  logic              clken_i,
   input  logic              host_addr_ld_i,
   input  logic [ADDR_W-1:0] host_addr_i,
   input  logic              host_wr_i,
   input  logic [7:0]        host_wdata_i,
   input  logic              host_rd_i,
   output logic [7:0]        host_rdata_o,
   output logic              host_rvalid_o,
   input  logic              go_i,
   input  logic              abort_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_busy_o,
   output logic              wrapped_o,
   output logic              eng_start_o,
   output logic              eng_reset_o,
   input  logic              eng_running_i,
   input  logic              eng_inc_i,
   output logic [7:0]        eng_mdat_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic              mem_we_o,
   output logic [7:0]        mem_wdata_o,
   input  logic [7:0]        mem_rdata_i,
   output logic [2:0]        state_o
);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] hptr_q, hptr_d;
   logic [7:0]        host_rdata_q, host_rdata_d;
   logic              host_rvalid_q, host_rvalid_d;
   logic              err_busy_q, err_busy_d;
   logic              wrapped_q, wrapped_d;
   logic              eng_reset_q, eng_reset_d;
   logic              pf_load, pf_active, pf_wrap;
   logic [ADDR_W-1:0] pf_addr;
   logic              host_any;

   assign host_any  = host_addr_ld_i | host_wr_i | host_rd_i;
   assign pf_active = (state_q == ST_ARM) || (state_q == ST_RUN);

   disc_write_memctl_prefetch #(.ADDR_W(ADDR_W)) u_prefetch (
      .clock_i      (clock_i),
      .reset_i      (reset_i),
      .load_i       (pf_load),
      .base_i       (hptr_q),
      .active_i     (pf_active),
      .clken_i      (clken_i),
      .eng_inc_i    (eng_inc_i),
      .mem_rdata_i  (mem_rdata_i),
      .eng_mdat_o   (eng_mdat_o),
      .fetch_addr_o (pf_addr),
      .wrap_o       (pf_wrap)
   );

   always_comb begin
      state_d       = state_q;
      hptr_d        = hptr_q;
      host_rdata_d  = host_rdata_q;
      host_rvalid_d = 1'b0;
      err_busy_d    = err_busy_q;
      wrapped_d     = wrapped_q | pf_wrap;
      eng_reset_d   = 1'b0;
      pf_load       = 1'b0;
      mem_we_o      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (host_addr_ld_i) begin
               hptr_d     = host_addr_i;
               err_busy_d = 1'b0;
            end else if (host_wr_i) begin
               mem_we_o = 1'b1;
               hptr_d   = hptr_q + ADDR_W'(1);
            end else if (host_rd_i) begin
               state_d = ST_HRD;
            end else if (go_i) begin
               pf_load   = 1'b1;
               wrapped_d = 1'b0;
               state_d   = ST_PRIME;
            end
         end
         ST_HRD: begin
            host_rdata_d  = mem_rdata_i;
            host_rvalid_d = 1'b1;
            hptr_d        = hptr_q + ADDR_W'(1);
            state_d       = ST_IDLE;
         end
         ST_PRIME: state_d = ST_ARM;
         ST_ARM:   if (clken_i && eng_inc_i) state_d = ST_RUN;
         ST_RUN:   if (!eng_running_i) state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
      // Abort overrides any natural progression and resets the engine once.
      if (abort_i && (state_q == ST_PRIME || state_q == ST_ARM || state_q == ST_RUN)) begin
         eng_reset_d = 1'b1;
         state_d     = ST_DONE;
      end
      if (is_busy_state(state_q) && host_any) err_busy_d = 1'b1;
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q       <= ST_IDLE;
         hptr_q        <= '0;
         host_rdata_q  <= '0;
         host_rvalid_q <= 1'b0;
         err_busy_q    <= 1'b0;
         wrapped_q     <= 1'b0;
         eng_reset_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         hptr_q        <= hptr_d;
         host_rdata_q  <= host_rdata_d;
         host_rvalid_q <= host_rvalid_d;
         err_busy_q    <= err_busy_d;
         wrapped_q     <= wrapped_d;
         eng_reset_q   <= eng_reset_d;
      end
   end

   assign mem_addr_o    = (state_q == ST_IDLE || state_q == ST_HRD) ? hptr_q : pf_addr;
   assign mem_wdata_o   = host_wdata_i;
   assign host_rdata_o  = host_rdata_q;
   assign host_rvalid_o = host_rvalid_q;
   assign busy_o        = is_busy_state(state_q);
   assign done_o        = (state_q == ST_DONE);
   assign eng_start_o   = (state_q == ST_ARM);
   assign eng_reset_o   = eng_reset_q;
   assign err_busy_o    = err_busy_q;
   assign wrapped_o     = wrapped_q;
   assign state_o       = state_q;

endmodule

// File: tb/tb_disc_write_memctl.sv
// Directed bench for disc_write_memctl: host load/readback, engine runs at
// several clock-enable rates, pointer wrap, busy lockout and abort.
module tb_disc_write_memctl;

  localparam int AW = 17;

  logic          clk = 1'b0;
  logic          rst;
  logic          clken = 1'b0;
  logic          host_addr_ld, host_wr, host_rd, go, abort;
  logic [AW-1:0] host_addr;
  logic [7:0]    host_wdata, host_rdata, eng_mdat, mem_wdata;
  logic [7:0]    mem_rdata = 8'h00;
  logic          host_rvalid, busy, done, err_busy, wrapped;
  logic          eng_start, eng_reset, eng_running, eng_inc, mem_we;
  logic [AW-1:0] mem_addr;
  logic [2:0]    dbg_state;

  logic [7:0]    ram [0:(1<<AW)-1];
  logic [7:0]    exp_q[$];
  int            n_chk = 0;
  int            n_err = 0;
  int            extra_cnt = 0;
  int            clk_div = 1;
  int            ccnt = 0;
  logic          run_q;
  logic          pend_inc = 1'b0;
  logic          pend_rst = 1'b0;
  logic [7:0]    pend_byte = 8'h00;

  always #5 clk = ~clk;

  disc_write_memctl #(.ADDR_W(AW)) dut (
    .clock_i(clk), .reset_i(rst), .clken_i(clken),
    .host_addr_ld_i(host_addr_ld), .host_addr_i(host_addr),
    .host_wr_i(host_wr), .host_wdata_i(host_wdata), .host_rd_i(host_rd),
    .host_rdata_o(host_rdata), .host_rvalid_o(host_rvalid),
    .go_i(go), .abort_i(abort), .busy_o(busy), .done_o(done),
    .err_busy_o(err_busy), .wrapped_o(wrapped),
    .eng_start_o(eng_start), .eng_reset_o(eng_reset),
    .eng_running_i(eng_running), .eng_inc_i(eng_inc), .eng_mdat_o(eng_mdat),
    .mem_addr_o(mem_addr), .mem_we_o(mem_we), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata), .state_o(dbg_state)
  );

  // single-port RAM, registered read
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  // engine model: increments on start and while running, stops after STOP
  assign eng_inc     = clken & ~eng_reset & (eng_start | run_q);
  assign eng_running = run_q;

  always @(posedge clk or posedge rst) begin
    if (rst) run_q <= 1'b0;
    else if (pend_rst) run_q <= 1'b0;
    else if (pend_inc) run_q <= (pend_byte != 8'h3F);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // clken generation plus scoreboard of bytes the engine latches
  always @(negedge clk) begin
    clken = ((ccnt % clk_div) == 0);
    ccnt++;
    #1;
    pend_inc  = eng_inc;
    pend_byte = eng_mdat;
    pend_rst  = eng_reset;
    if (pend_inc) begin
      if (exp_q.size() > 0) chk("instr_byte", {24'h0, pend_byte}, {24'h0, exp_q.pop_front()});
      else extra_cnt++;
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic host_ld(input logic [AW-1:0] a);
    host_addr_ld = 1'b1; host_addr = a;
    tick();
    host_addr_ld = 1'b0;
  endtask

  task automatic host_write(input logic [7:0] d);
    host_wr = 1'b1; host_wdata = d;
    #1 chk("mem_we_idle", {31'h0, mem_we}, 32'h1);
    tick();
    host_wr = 1'b0;
  endtask

  task automatic host_read(input string tag, input logic [7:0] exp);
    host_rd = 1'b1;
    tick();
    host_rd = 1'b0;
    chk("rvalid_early", {31'h0, host_rvalid}, 32'h0);
    tick();
    chk("rvalid", {31'h0, host_rvalid}, 32'h1);
    chk(tag, {24'h0, host_rdata}, {24'h0, exp});
  endtask

  task automatic push_prog(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input int n);
    exp_q.delete();
    extra_cnt = 0;
    exp_q.push_back(b0);
    exp_q.push_back(b1);
    if (n > 2) exp_q.push_back(b2);
  endtask

  task automatic start_go();
    go = 1'b1;
    tick();
    go = 1'b0;
    chk("start_prime", {31'h0, eng_start}, 32'h0);
    chk("busy_prime", {31'h0, busy}, 32'h1);
    tick();
    chk("start_arm", {31'h0, eng_start}, 32'h1);
  endtask

  task automatic wait_run();
    for (int i = 0; i < 30; i++) begin
      if (!eng_start) break;
      tick();
    end
    chk("reach_run", {29'h0, dbg_state}, 32'h4);
  endtask

  task automatic wait_done();
    int fall_cyc = -100;
    int done_cyc = -1;
    logic prev = run_q;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (prev && !run_q) fall_cyc = i;
      prev = run_q;
      if (done) begin
        done_cyc = i;
        break;
      end
    end
    chk("done_seen", {31'h0, (done_cyc >= 0)}, 32'h1);
    chk("done_latency", done_cyc - fall_cyc, 32'h1);
    tick();
    chk("busy_after_done", {31'h0, busy}, 32'h0);
    chk("bytes_left", exp_q.size(), 32'h0);
    chk("extra_bytes", extra_cnt, 32'h0);
  endtask

  initial begin
    int rst_cnt;
    rst = 1'b1;
    host_addr_ld = 1'b0; host_wr = 1'b0; host_rd = 1'b0; go = 1'b0; abort = 1'b0;
    host_addr = '0; host_wdata = 8'h00;
    repeat (3) tick();
    chk("rst_state", {29'h0, dbg_state}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_rvalid", {31'h0, host_rvalid}, 32'h0);
    chk("rst_err_busy", {31'h0, err_busy}, 32'h0);
    chk("rst_wrapped", {31'h0, wrapped}, 32'h0);
    chk("rst_eng_start", {31'h0, eng_start}, 32'h0);
    chk("rst_eng_reset", {31'h0, eng_reset}, 32'h0);
    chk("rst_mem_addr", {15'h0, mem_addr}, 32'h0);
    rst = 1'b0;
    tick();

    // host load and readback
    host_ld(17'h00100);
    host_write(8'h02); host_write(8'h02); host_write(8'h3F);
    chk("hptr_after_wr", {15'h0, mem_addr}, 32'h00103);
    host_ld(17'h00100);
    host_read("rd0", 8'h02); host_read("rd1", 8'h02); host_read("rd2", 8'h3F);
    chk("hptr_after_rd", {15'h0, mem_addr}, 32'h00103);

    // run with clken every clock
    clk_div = 1;
    host_ld(17'h00100);
    push_prog(8'h02, 8'h02, 8'h3F, 3);
    start_go();
    wait_done();

    // same program, clken every 7th clock
    clk_div = 7;
    host_ld(17'h00100);
    push_prog(8'h02, 8'h02, 8'h3F, 3);
    start_go();
    wait_done();

    // wrap past the top of RAM
    clk_div = 1;
    host_ld(17'h1FFFF);
    host_write(8'h02); host_write(8'h3F);
    chk("hptr_wrap_host", {15'h0, mem_addr}, 32'h00001);
    host_ld(17'h1FFFF);
    push_prog(8'h02, 8'h3F, 8'h00, 2);
    start_go();
    wait_done();
    chk("wrapped_set", {31'h0, wrapped}, 32'h1);

    // host write during a run is refused
    clk_div = 7;
    host_ld(17'h00100);
    push_prog(8'h02, 8'h02, 8'h3F, 3);
    start_go();
    chk("wrapped_cleared", {31'h0, wrapped}, 32'h0);
    wait_run();
    host_wr = 1'b1; host_wdata = 8'hAA;
    #1 chk("mem_we_busy", {31'h0, mem_we}, 32'h0);
    tick();
    host_wr = 1'b0;
    chk("err_busy_set", {31'h0, err_busy}, 32'h1);
    wait_done();
    chk("ram_untouched", {24'h0, ram[17'h00100]}, 32'h02);
    chk("hptr_unmoved", {15'h0, mem_addr}, 32'h00100);
    host_ld(17'h00100);
    chk("err_busy_clr", {31'h0, err_busy}, 32'h0);
    host_read("rd_after_busy", 8'h02);

    // abort mid-run, then a fresh run
    clk_div = 7;
    host_ld(17'h00100);
    push_prog(8'h02, 8'h02, 8'h3F, 3);
    start_go();
    wait_run();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_eng_reset", {31'h0, eng_reset}, 32'h1);
    chk("abort_done", {31'h0, done}, 32'h1);
    rst_cnt = 1;
    tick();
    chk("abort_busy_low", {31'h0, busy}, 32'h0);
    rst_cnt += int'(eng_reset);
    repeat (3) begin
      tick();
      rst_cnt += int'(eng_reset);
    end
    chk("eng_reset_len", rst_cnt, 32'h1);
    clk_div = 1;
    host_ld(17'h00100);
    push_prog(8'h02, 8'h02, 8'h3F, 3);
    start_go();
    wait_done();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
